// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - command and status bundle for the countdown timer
interface countdown_timer_if;
   logic       start;
   logic       pause;
   logic       stop;
   logic       load;
   logic [3:0] ld_min_l;
   logic [3:0] ld_min_r;
   logic [3:0] ld_sec_l;
   logic [3:0] ld_sec_r;
   logic [3:0] min_l;
   logic [3:0] min_r;
   logic [3:0] sec_l;
   logic [3:0] sec_r;
   logic       busy;
   logic       done;
   logic       alarm;

   modport master (
      output start, pause, stop, load,
      output ld_min_l, ld_min_r, ld_sec_l, ld_sec_r,
      input  min_l, min_r, sec_l, sec_r,
      input  busy, done, alarm
   );

   modport slave (
      input  start, pause, stop, load,
      input  ld_min_l, ld_min_r, ld_sec_l, ld_sec_r,
      output min_l, min_r, sec_l, sec_r,
      output busy, done, alarm
   );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - MM:SS BCD countdown timer with run/pause/stop control and expiry alarm
// Build option ALARM_BLINK_EN: alarm blinks at 2 Hz in EXPIRED instead of holding high.
module countdown_timer #(
   parameter int CLK_HZ = 100000000
) (
   input  logic             clk,
   input  logic             rst,
   countdown_timer_if.slave bus
);
   localparam int PW = $clog2(CLK_HZ);
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

   state_t        state_q, state_d;
   logic [3:0]    min_l_q, min_l_d, min_r_q, min_r_d;
   logic [3:0]    sec_l_q, sec_l_d, sec_r_q, sec_r_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          done_q, done_d;

   logic [3:0] sat_min_l, sat_min_r, sat_sec_l, sat_sec_r;
   logic [3:0] dec_min_l, dec_min_r, dec_sec_l, dec_sec_r;
   logic       preset_zero, cur_zero, dec_zero;

   // Presets clamp to the largest legal BCD digit for their position.
   always_comb begin
      sat_min_l   = (bus.ld_min_l > 4'd9) ? 4'd9 : bus.ld_min_l;
      sat_min_r   = (bus.ld_min_r > 4'd9) ? 4'd9 : bus.ld_min_r;
      sat_sec_l   = (bus.ld_sec_l > 4'd5) ? 4'd5 : bus.ld_sec_l;
      sat_sec_r   = (bus.ld_sec_r > 4'd9) ? 4'd9 : bus.ld_sec_r;
      preset_zero = ({sat_min_l, sat_min_r, sat_sec_l, sat_sec_r} == 16'h0000);
      cur_zero    = ({min_l_q, min_r_q, sec_l_q, sec_r_q} == 16'h0000);
   end

   always_comb begin
      dec_sec_r = sec_r_q - 4'd1;
      dec_sec_l = sec_l_q;
      dec_min_r = min_r_q;
      dec_min_l = min_l_q;
      if (sec_r_q == 4'd0) begin
         dec_sec_r = 4'd9;
         dec_sec_l = sec_l_q - 4'd1;
         if (sec_l_q == 4'd0) begin
            dec_sec_l = 4'd5;
            dec_min_r = min_r_q - 4'd1;
            if (min_r_q == 4'd0) begin
               dec_min_r = 4'd9;
               dec_min_l = min_l_q - 4'd1;
            end
         end
      end
      dec_zero = ({dec_min_l, dec_min_r, dec_sec_l, dec_sec_r} == 16'h0000);
   end

   always_comb begin
      state_d = state_q;
      min_l_d = min_l_q;
      min_r_d = min_r_q;
      sec_l_d = sec_l_q;
      sec_r_d = sec_r_q;
      presc_d = presc_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!bus.stop) begin
               if (bus.load) begin
                  min_l_d = sat_min_l;
                  min_r_d = sat_min_r;
                  sec_l_d = sat_sec_l;
                  sec_r_d = sat_sec_r;
               end
               // A same-cycle load means start must judge the freshly loaded value.
               if (bus.start && (bus.load ? !preset_zero : !cur_zero)) begin
                  state_d = RUN;
                  presc_d = '0;
               end
            end
         end
         RUN: begin
            if (bus.stop) begin
               state_d = IDLE;
               presc_d = '0;
            end else if (bus.pause) begin
               state_d = PAUSE;
            end else if (presc_q == PRESC_MAX) begin
               presc_d = '0;
               min_l_d = dec_min_l;
               min_r_d = dec_min_r;
               sec_l_d = dec_sec_l;
               sec_r_d = dec_sec_r;
               if (dec_zero) begin
                  state_d = EXPIRED;
                  done_d  = 1'b1;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         PAUSE: begin
            if (bus.stop) begin
               state_d = IDLE;
               presc_d = '0;
            end else if (bus.start) begin
               state_d = RUN;
            end
         end
         EXPIRED: begin
            if (bus.stop || bus.start) begin
               state_d = IDLE;
            end else if (bus.load) begin
               state_d = IDLE;
               min_l_d = sat_min_l;
               min_r_d = sat_min_r;
               sec_l_d = sat_sec_l;
               sec_r_d = sat_sec_r;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         min_l_q <= 4'd0;
         min_r_q <= 4'd0;
         sec_l_q <= 4'd0;
         sec_r_q <= 4'd0;
         presc_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         min_l_q <= min_l_d;
         min_r_q <= min_r_d;
         sec_l_q <= sec_l_d;
         sec_r_q <= sec_r_d;
         presc_q <= presc_d;
         done_q  <= done_d;
      end
   end

`ifdef ALARM_BLINK_EN
   localparam logic [PW-1:0] BLINK_MAX = PW'(CLK_HZ / 4 - 1);

   logic [PW-1:0] blink_q, blink_d;
   logic          alarm_q, alarm_d;

   // Entering EXPIRED restarts the blink phase with the alarm lit.
   always_comb begin
      blink_d = '0;
      alarm_d = 1'b0;
      if (state_d == EXPIRED) begin
         if (state_q != EXPIRED) begin
            alarm_d = 1'b1;
         end else if (blink_q == BLINK_MAX) begin
            alarm_d = !alarm_q;
         end else begin
            blink_d = blink_q + 1'b1;
            alarm_d = alarm_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_q <= '0;
         alarm_q <= 1'b0;
      end else begin
         blink_q <= blink_d;
         alarm_q <= alarm_d;
      end
   end

   assign bus.alarm = alarm_q;
`else
   assign bus.alarm = (state_q == EXPIRED);
`endif

   assign bus.min_l = min_l_q;
   assign bus.min_r = min_r_q;
   assign bus.sec_l = sec_l_q;
   assign bus.sec_r = sec_r_q;
   assign bus.busy  = (state_q == RUN) || (state_q == PAUSE);
   assign bus.done  = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed self-checking bench for countdown_timer at CLK_HZ=8
module tb_countdown_timer;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   logic [15:0] tm;

   countdown_timer_if ifc ();

   countdown_timer #(.CLK_HZ(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   assign tm = {ifc.min_l, ifc.min_r, ifc.sec_l, ifc.sec_r};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic preset(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
      ifc.ld_min_l = a;
      ifc.ld_min_r = b;
      ifc.ld_sec_l = c;
      ifc.ld_sec_r = d;
   endtask

   task automatic pulse_load();
      ifc.load = 1'b1;
      tick();
      ifc.load = 1'b0;
   endtask

   task automatic pulse_start();
      ifc.start = 1'b1;
      tick();
      ifc.start = 1'b0;
   endtask

   task automatic pulse_stop();
      ifc.stop = 1'b1;
      tick();
      ifc.stop = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b0;
      ifc.start = 1'b0;
      ifc.pause = 1'b0;
      ifc.stop  = 1'b0;
      ifc.load  = 1'b0;
      preset(4'd0, 4'd0, 4'd0, 4'd0);
      tick(2);
      check("rst_digits", 32'(tm), 32'h0000);
      check("rst_busy",   32'(ifc.busy), 32'd0);
      check("rst_done",   32'(ifc.done), 32'd0);
      check("rst_alarm",  32'(ifc.alarm), 32'd0);
      rst = 1'b1;
      tick();

      // 00:03 full countdown to expiry
      preset(4'd0, 4'd0, 4'd0, 4'd3);
      pulse_load();
      check("load_0003", 32'(tm), 32'h0003);
      pulse_start();
      check("run_busy", 32'(ifc.busy), 32'd1);
      tick(7);
      check("pre_dec1", 32'(tm), 32'h0003);
      tick();
      check("dec1", 32'(tm), 32'h0002);
      tick(8);
      check("dec2", 32'(tm), 32'h0001);
      tick(7);
      check("no_early_done", 32'(ifc.done), 32'd0);
      tick();
      check("dec3", 32'(tm), 32'h0000);
      check("done_pulse", 32'(ifc.done), 32'd1);
      check("alarm_entry", 32'(ifc.alarm), 32'd1);
      check("exp_busy", 32'(ifc.busy), 32'd0);
      tick();
      check("done_once", 32'(ifc.done), 32'd0);
`ifdef ALARM_BLINK_EN
      check("blink_1", 32'(ifc.alarm), 32'd1);
      tick();
      check("blink_2", 32'(ifc.alarm), 32'd0);
      tick();
      check("blink_3", 32'(ifc.alarm), 32'd0);
      tick();
      check("blink_4", 32'(ifc.alarm), 32'd1);
`else
      tick(3);
      check("alarm_held", 32'(ifc.alarm), 32'd1);
`endif
      pulse_start();
      check("ack_alarm", 32'(ifc.alarm), 32'd0);
      check("ack_busy",  32'(ifc.busy), 32'd0);

      // minute borrows
      preset(4'd0, 4'd1, 4'd0, 4'd0);
      pulse_load();
      pulse_start();
      tick(8);
      check("borrow_0100", 32'(tm), 32'h0059);
      pulse_stop();
      preset(4'd1, 4'd0, 4'd0, 4'd0);
      pulse_load();
      pulse_start();
      tick(8);
      check("borrow_1000", 32'(tm), 32'h0959);
      preset(4'd0, 4'd0, 4'd0, 4'd1);
      pulse_load();
      check("load_ign_run", 32'(tm), 32'h0959);
      check("load_ign_busy", 32'(ifc.busy), 32'd1);
      pulse_stop();
      check("stop_retain", 32'(tm), 32'h0959);
      check("stop_idle", 32'(ifc.busy), 32'd0);

      // pause at prescaler 5, resume
      pulse_start();
      tick(5);
      ifc.pause = 1'b1;
      tick();
      ifc.pause = 1'b0;
      check("pause_busy", 32'(ifc.busy), 32'd1);
      tick(20);
      check("pause_frozen", 32'(tm), 32'h0959);
      pulse_start();
      tick(2);
      check("resume_pre", 32'(tm), 32'h0959);
      tick();
      check("resume_dec", 32'(tm), 32'h0958);

      // stop on terminal count suppresses decrement and clears prescaler
      tick(7);
      pulse_stop();
      check("stop_tc_digits", 32'(tm), 32'h0958);
      check("stop_tc_idle", 32'(ifc.busy), 32'd0);
      pulse_start();
      tick(7);
      check("presc_clr_pre", 32'(tm), 32'h0958);
      tick();
      check("presc_clr_dec", 32'(tm), 32'h0957);

      // asynchronous reset mid-run
      tick(3);
      #2;
      rst = 1'b0;
      #1;
      check("arst_digits", 32'(tm), 32'h0000);
      check("arst_busy",   32'(ifc.busy), 32'd0);
      tick(10);
      check("arst_done",   32'(ifc.done), 32'd0);
      check("arst_alarm",  32'(ifc.alarm), 32'd0);
      rst = 1'b1;
      tick();

      // saturation and zero start
      preset(4'd0, 4'd12, 4'd7, 4'd15);
      pulse_load();
      check("sat_sec_min", 32'(tm), 32'h0959);
      preset(4'd10, 4'd0, 4'd0, 4'd0);
      pulse_load();
      check("sat_min_l", 32'(tm), 32'h9000);
      preset(4'd0, 4'd0, 4'd0, 4'd0);
      pulse_load();
      pulse_start();
      check("zero_start", 32'(ifc.busy), 32'd0);
      tick(3);
      check("zero_stay", 32'(ifc.busy), 32'd0);

      // stop outranks load in IDLE
      preset(4'd4, 4'd4, 4'd4, 4'd4);
      ifc.stop = 1'b1;
      ifc.load = 1'b1;
      tick();
      ifc.stop = 1'b0;
      ifc.load = 1'b0;
      check("stop_over_load", 32'(tm), 32'h0000);

      // same-cycle load and start
      preset(4'd0, 4'd0, 4'd0, 4'd1);
      ifc.load  = 1'b1;
      ifc.start = 1'b1;
      tick();
      ifc.load  = 1'b0;
      ifc.start = 1'b0;
      check("ldst_busy", 32'(ifc.busy), 32'd1);
      tick(8);
      check("ldst_expire", 32'(tm), 32'h0000);
      check("ldst_done", 32'(ifc.done), 32'd1);
      preset(4'd2, 4'd3, 4'd4, 4'd5);
      pulse_load();
      check("exp_load_cap", 32'(tm), 32'h2345);
      check("exp_load_alarm", 32'(ifc.alarm), 32'd0);
      check("exp_load_idle", 32'(ifc.busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter CLK_HZ, default 100000000, gives clock cycles per one-second count step; it SHALL be at least 4.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse that starts or resumes the countdown, and acknowledges the alarm.
REQ-005 pause  input  1  one-cycle pulse that suspends a running countdown.
REQ-006 stop  input  1  one-cycle pulse that aborts to IDLE and acknowledges the alarm.
REQ-007 load  input  1  one-cycle pulse that captures the preset digits.
REQ-008 ld_min_l, ld_min_r, ld_sec_l, ld_sec_r  input  4 each  preset digits, BCD.
REQ-009 min_l, min_r, sec_l, sec_r  output  4 each  current remaining time, BCD, in MM:SS order.
REQ-010 busy  output  1  high in RUN or PAUSE.
REQ-011 done  output  1  one-cycle pulse on expiry.
REQ-012 alarm  output  1  alarm indicator, active only in EXPIRED.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN, PAUSE and EXPIRED.
REQ-014 Input priority SHALL be stop > load > start > pause when inputs coincide.
REQ-015 IDLE behaviour:
- load captures the preset digits.
- ld_min_l, ld_min_r and ld_sec_r values above 9 saturate to 9.
- ld_sec_l values above 5 saturate to 5.
REQ-016 IDLE, start: go to RUN and clear the prescaler only if the digits are not 00:00; at 00:00, stay in IDLE.
REQ-017 IDLE, same-cycle load and start: start SHALL evaluate the newly loaded value, so RUN begins the following cycle.
REQ-018 RUN, prescaler:
- Counts 0 to CLK_HZ-1, then wraps to 0.
- On reaching CLK_HZ-1, the time decrements by one second.
REQ-019 Decrement borrow rules:
- sec_r 0 becomes 9 and borrows from sec_l.
- sec_l 0 becomes 5 and borrows from min_r.
- min_r 0 becomes 9 and borrows from min_l.
- min_l decrements.
REQ-020 When a decrement yields 00:00, the FSM SHALL enter EXPIRED and assert done in the same cycle the digits become 00:00.
REQ-021 RUN, pause: go to PAUSE with the prescaler frozen.
REQ-022 PAUSE, start: return to RUN with the prescaler resuming from its frozen value.
REQ-023 RUN or PAUSE, stop: go to IDLE, digits retained, prescaler cleared.
REQ-024 A stop coinciding with the prescaler terminal count SHALL suppress that decrement.
REQ-025 load and start SHALL be ignored in RUN; load SHALL be ignored in PAUSE.
REQ-026 EXPIRED: alarm active, digits 00:00; start, stop or load returns to IDLE, and load also captures the presets.
REQ-027 alarm SHALL be low in every state other than EXPIRED.
REQ-028 Maximum preset is 99:59; no wrap below 00:00 is possible.

Reset
REQ-029 While rst is low, the block SHALL force state IDLE, all digits 0, prescaler 0, busy 0, done 0, alarm 0.
REQ-030 Reset asserted mid-RUN SHALL abort the countdown immediately without a done pulse.

Configuration
REQ-031 Macro ALARM_BLINK_EN selects the alarm behaviour:
- Defined: in EXPIRED, alarm starts high and toggles every CLK_HZ/4 cycles (2 Hz blink), with a blink counter cleared on entry.
- Undefined: alarm is held high throughout EXPIRED and no blink counter is built.

Verification (CLK_HZ=8)
REQ-032 load 00:03, start -> busy=1; digits 00:02, 00:01, 00:00 at 8-cycle spacing; done pulses once; alarm=1.
REQ-033 load 01:00, start, wait 8 cycles -> 00:59; load 10:00, run 8 cycles -> 09:59.
REQ-034 pause at prescaler 5, hold 20 cycles, start -> next decrement 3 cycles after resume, digits unchanged during PAUSE.
REQ-035 load with ld_sec_l=7, ld_min_r=12 -> captured 5 and 9; start at 00:00 -> stays IDLE, busy=0.
REQ-036 stop on the terminal prescaler cycle -> IDLE, no decrement; rst low mid-RUN -> all outputs 0, no done.
REQ-037 In EXPIRED with ALARM_BLINK_EN: alarm toggles every 2 cycles until start, then alarm=0 and state IDLE.
